// File: rtl/axi_mem_responder.sv
// Memory-side AXI-style responder: fixed-length read bursts and absorbed write bursts
// against an internal 64-bit word array, with independent read and write channels.
module axi_mem_responder #(
  parameter int MEM_WORDS          = 4096,
  parameter int BEATS_PER_BURST    = 8,
  parameter int READ_LATENCY       = 2,
  parameter int WRITE_RESP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic        s_axi_rvalid,
  output logic        s_axi_rlast,
  input  logic        s_axi_rready,
  input  logic [63:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  input  logic        s_axi_wlast,
  output logic        s_axi_wready,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic        protocol_err
);
  localparam int AW  = $clog2(MEM_WORDS);
  localparam int BW  = $clog2(BEATS_PER_BURST);
  localparam int RLW = $clog2(READ_LATENCY + 1);
  localparam int WLW = $clog2(WRITE_RESP_LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_BURST - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // valid, data and last are held unchanged until that edge.

  logic [63:0] mem [MEM_WORDS];

  r_state_t         r_state;
  logic [AW-BW-1:0] rd_line;
  logic [BW-1:0]    rd_beat;
  logic [RLW-1:0]   rd_cnt;

  w_state_t         w_state;
  logic [AW-BW-1:0] wr_line;
  logic [BW-1:0]    wr_beat;
  logic [WLW-1:0]   wr_cnt;

  logic [AW-BW-1:0] ar_line;
  logic [AW-BW-1:0] aw_line;
  logic             wr_last;
  logic             w_fire;
  logic             unused_addr_bits;

  // A line is BEATS_PER_BURST words, so the word index is {line, beat} and the top bits
  // dropped here give the silent wrap past the end of the array.
  assign ar_line = s_axi_araddr[3+BW +: AW-BW];
  assign aw_line = s_axi_awaddr[3+BW +: AW-BW];
  assign unused_addr_bits = ^{s_axi_araddr[63:3+AW], s_axi_araddr[2+BW:0],
                              s_axi_awaddr[63:3+AW], s_axi_awaddr[2+BW:0]};

  assign s_axi_arready = !reset && (r_state == R_IDLE);
  assign s_axi_rvalid  = !reset && (r_state == R_SEND);
  assign s_axi_rlast   = s_axi_rvalid && (rd_beat == LAST_BEAT);
  assign s_axi_rdata   = s_axi_rvalid ? mem[{rd_line, rd_beat}] : '0;

  assign s_axi_awready = !reset && (w_state == W_IDLE);
  assign s_axi_wready  = !reset && (w_state == W_DATA);
  assign s_axi_bvalid  = !reset && (w_state == W_RESP);

  assign wr_last = (wr_beat == LAST_BEAT);
  assign w_fire  = s_axi_wvalid && s_axi_wready;

  // Unreset array write; a read in the same cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (w_fire) mem[{wr_line, wr_beat}] <= s_axi_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      rd_line <= '0;
      rd_beat <= '0;
      rd_cnt  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          rd_line <= ar_line;
          rd_beat <= '0;
          rd_cnt  <= RLW'(READ_LATENCY - 1);
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (rd_cnt == '0) r_state <= R_SEND;
          else              rd_cnt  <= rd_cnt - RLW'(1);
        end
        R_SEND: if (s_axi_rready) begin
          rd_beat <= rd_beat + BW'(1);
          if (rd_beat == LAST_BEAT) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state      <= W_IDLE;
      wr_line      <= '0;
      wr_beat      <= '0;
      wr_cnt       <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          wr_line <= aw_line;
          wr_beat <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          wr_beat <= wr_beat + BW'(1);
          // Burst ends on whichever comes first: wlast or the final beat count.
          if (s_axi_wlast || wr_last) begin
            if (s_axi_wlast != wr_last) protocol_err <= 1'b1;
            wr_cnt  <= WLW'(WRITE_RESP_LATENCY - 1);
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_cnt == '0) w_state <= W_RESP;
          else              wr_cnt  <= wr_cnt - WLW'(1);
        end
        W_RESP: if (s_axi_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed bursts plus random traffic against a word-array
// reference model updated at each accepted write beat.
module tb_axi_mem_responder;
  localparam int MEM_WORDS = 4096;
  localparam int BEATS     = 8;
  localparam int RLAT      = 2;
  localparam int WLAT      = 1;

  typedef logic [63:0] burst_t [BEATS];

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        protocol_err;

  logic [63:0] model_mem [MEM_WORDS];
  bit          model_err;
  logic [63:0] written[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .BEATS_PER_BURST(BEATS),
    .READ_LATENCY(RLAT), .WRITE_RESP_LATENCY(WLAT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rlast(rlast), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wlast(wlast), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word touched by beat k of a burst at byte address addr (64-byte lines, wrapping).
  function automatic int word_of(input logic [63:0] addr, input int k);
    return int'(((addr / 64) * BEATS + k) % MEM_WORDS);
  endfunction

  // mode 0: rready always high, 1: toggles every cycle, 2: random
  task automatic do_read(input logic [63:0] addr, input int mode);
    int cyc, lat, beat, guard;
    bit rr;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; cyc = 0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    check("ar_wait", cyc, 0);
    @(negedge clk);
    arvalid = 1'b0; araddr = '0; lat = 0;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    check("rd_latency", lat, RLAT);
    beat = 0; guard = 0; rr = 1'b0;
    while (beat < BEATS && guard < 100) begin
      check("rvalid", rvalid, 1);
      check("rdata", rdata, model_mem[word_of(addr, beat)]);
      check("rlast", rlast, beat == BEATS - 1);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ~rr : 1'($urandom_range(0, 1));
      rready = rr;
      @(negedge clk);
      if (rr) beat++;
      guard++;
    end
    rready = 1'b0;
    check("rd_beats", beat, BEATS);
    check("rd_done_arready", arready, 1);
    check("rd_done_rvalid", rvalid, 0);
  endtask

  // last_at: beat carrying wlast (BEATS-1 is clean, >= BEATS means never asserted)
  task automatic do_write(input logic [63:0] addr, input burst_t d, input int last_at,
                          input int lead, input bit gaps);
    int cyc, lat, n, hold;
    n = (last_at < BEATS) ? last_at + 1 : BEATS;
    @(negedge clk);
    check("wready_idle", wready, 0);
    awaddr = addr; awvalid = 1'b1; cyc = 0;
    while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
    check("aw_wait", cyc, 0);
    @(negedge clk);
    awvalid = 1'b0; awaddr = '0;
    repeat (lead) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      wdata = d[k]; wlast = (k == last_at); wvalid = 1'b1;
      check("wready", wready, 1);
      @(posedge clk);
      model_mem[word_of(addr, k)] = d[k];
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0; wdata = '0;
    end
    if (last_at != BEATS - 1) model_err = 1'b1;
    written.push_back(addr);
    check("wready_after_last", wready, 0);
    lat = 0;
    while (!bvalid && lat < 50) begin @(negedge clk); lat++; end
    check("b_latency", lat, WLAT);
    check("protocol_err", protocol_err, model_err);
    hold = gaps ? $urandom_range(0, 2) : 0;
    repeat (hold) begin @(negedge clk); check("bvalid_hold", bvalid, 1); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
    check("awready_after_b", awready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    burst_t d;
    int cyc;
    logic [63:0] a;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
    model_err = 1'b0;
    reset = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_err", protocol_err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_arready", arready, 1);
    check("post_rst_awready", awready, 1);

    // Lines read later are written first so no test depends on power-up contents.
    for (int i = 0; i < BEATS; i++) d[i] = 64'h1000 + 64'(i);
    do_write(64'h1000, d, BEATS - 1, 0, 0);
    for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
    do_write(64'h0, d, BEATS - 1, 0, 1);
    do_write(64'h400, d, BEATS - 1, 1, 0);
    for (int i = 0; i < BEATS; i++) d[i] = '0;
    do_write(64'h3000, d, BEATS - 1, 0, 0);

    do_read(64'h1000, 0);

    for (int i = 0; i < BEATS; i++) d[i] = 64'hA0 + 64'(i);
    do_write(64'h2010, d, BEATS - 1, 0, 0);
    do_read(64'h2000, 1);

    // AR and AW accepted on the same edge, same line; writes trail reads by varying gaps.
    for (int i = 0; i < BEATS; i++) d[i] = '1;
    fork
      do_read(64'h3018, 0);
      do_write(64'h3000, d, BEATS - 1, 1, 1);
    join
    do_read(64'h3000, 2);

    // Early wlast on beat 3: only words 0-3 change, flag sticks across clean bursts.
    for (int i = 0; i < BEATS; i++) d[i] = 64'h5500 + 64'(i);
    do_write(64'h400, d, 3, 0, 0);
    do_read(64'h400, 0);
    for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
    do_write(64'h2000, d, BEATS - 1, 0, 1);

    // Reset while beat 4 of a read is presented.
    @(negedge clk);
    araddr = 64'h1000; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; cyc = 0;
    while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
    check("mid_rst_rvalid_seen", rvalid, 1);
    rready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_beat4_data", rdata, model_mem[word_of(64'h1000, 4)]);
    check("mid_rst_beat4_rlast", rlast, 0);
    rready = 1'b0; reset = 1'b1;
    @(negedge clk);
    model_err = 1'b0;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 0);
    check("mid_rst_err", protocol_err, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_arready_after", arready, 1);
    do_read(64'(MEM_WORDS * 8), 0);
    do_read(64'h1000, 1);

    // Final beat without wlast.
    for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
    do_write(64'h5000, d, BEATS, 0, 1);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
        a = 64'($urandom_range(0, 63)) * 64 + 64'($urandom_range(0, 63))
            + 64'(MEM_WORDS * 8) * 64'($urandom_range(0, 2));
        do_write(a, d, BEATS - 1, $urandom_range(0, 2), 1);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)]
            + 64'(MEM_WORDS * 8) * 64'($urandom_range(0, 3));
        do_read(a, 2);
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
